ctrl_decode_pipe: RTL



---
 rtl/ctrl_decode_pipe_if.sv | 27 ++
 rtl/ctrl_decode_pipe.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ctrl_decode_pipe_if.sv
// ctrl_decode_pipe_if: bundles the fetch-side and execute-side valid/ready
// channels of the pipelined instruction decoder.
//    master : the environment (fetch producer + downstream consumer)
//    slave  : the decoder itself
interface ctrl_decode_pipe_if #(
   parameter int JADDR_W = 32
);
   logic               in_valid;
   logic               in_ready;
   logic [31:0]        instr;
   logic               out_valid;
   logic               out_ready;
   logic [24:0]        ctrl;
   logic [JADDR_W-1:0] jmp_addr;
   logic               jmp_flag;
   logic               illegal;

   modport master (
      output in_valid, instr, out_ready,
      input  in_ready, out_valid, ctrl, jmp_addr, jmp_flag, illegal
   );

   modport slave (
      input  in_valid, instr, out_ready,
      output in_ready, out_valid, ctrl, jmp_addr, jmp_flag, illegal
   );
endinterface

// File: rtl/ctrl_decode_pipe.sv
// ctrl_decode_pipe: registered, handshaked instruction decoder.
// Decodes a 32-bit instruction into a packed 25-bit control word
//    {rs, rt, rd, WR_regfile, mux_imm_regB, ALU_sel[1:0], mul_start,
//     mux2_ALU, WR_mem, CS_WB_2, branch, jmp}
// held in a one-entry output register. Blocks input while the multiplier
// is busy and drops the word that follows a taken jump.
// Optional build macro:
//    CTRL_LOAD_USE_INTERLOCK_EN - adds the one-cycle load-use stall.
//    Without it no hazard tracking is built at all.
module ctrl_decode_pipe #(
   parameter int JADDR_W    = 32,
   parameter int MUL_CYCLES = 4
) (
   input  logic              clk,
   input  logic              rst_n,
   ctrl_decode_pipe_if.slave bus
);

   localparam int CNT_W = $clog2(MUL_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MUL_CYCLES - 1);

   // Opcodes and R-type function codes
   localparam logic [5:0] OP_LW   = 6'd40;
   localparam logic [5:0] OP_SW   = 6'd41;
   localparam logic [5:0] OP_BNE  = 6'd42;
   localparam logic [5:0] OP_ADDI = 6'd43;
   localparam logic [5:0] OP_ORI  = 6'd44;
   localparam logic [5:0] OP_J    = 6'd2;
   localparam logic [5:0] FN_ADD  = 6'd32;
   localparam logic [5:0] FN_SUB  = 6'd34;
   localparam logic [5:0] FN_MUL  = 6'd50;
   localparam logic [5:0] FN_AND  = 6'd36;
   localparam logic [5:0] FN_OR   = 6'd37;

   // Low ten control bits:
   //   WR_regfile, mux_imm_regB, ALU_sel[1:0], mul_start,
   //   mux2_ALU, WR_mem, CS_WB_2, branch, jmp
   // ALU_sel: 00 add, 01 sub, 10 and, 11 or.
   // mux2_ALU selects the ALU result (1) versus the multiplier (0).
   // CS_WB_2 selects the execute result (1) versus memory data (0).
   localparam logic [9:0] C_LW   = 10'b1_1_00_0_1_0_0_0_0;
   localparam logic [9:0] C_SW   = 10'b0_1_00_0_1_1_0_0_0;
   localparam logic [9:0] C_BNE  = 10'b0_0_01_0_1_0_0_1_0;
   localparam logic [9:0] C_ADDI = 10'b1_1_00_0_1_0_1_0_0;
   localparam logic [9:0] C_ORI  = 10'b1_1_11_0_1_0_1_0_0;
   localparam logic [9:0] C_J    = 10'b0_0_00_0_0_0_0_0_1;
   localparam logic [9:0] C_ADD  = 10'b1_0_00_0_1_0_1_0_0;
   localparam logic [9:0] C_SUB  = 10'b1_0_01_0_1_0_1_0_0;
   localparam logic [9:0] C_AND  = 10'b1_0_10_0_1_0_1_0_0;
   localparam logic [9:0] C_OR   = 10'b1_0_11_0_1_0_1_0_0;
   localparam logic [9:0] C_MUL  = 10'b1_0_00_1_0_0_1_0_0;

   localparam int B_MUL = 5;
   localparam int B_JMP = 0;

   typedef enum logic [1:0] {
      ST_RUN      = 2'd0,
      ST_MUL_WAIT = 2'd1,
      ST_SQUASH   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [CNT_W-1:0]    r_cnt;
   logic [CNT_W-1:0]    w_cnt_next;
   logic                r_sq_pend;
   logic                w_sq_pend_next;

   logic                r_out_valid;
   logic [24:0]         r_ctrl;
   logic [JADDR_W-1:0]  r_jaddr;
   logic                r_illegal;

   logic [5:0]          w_opcode;
   logic [5:0]          w_funct;
   logic [4:0]          w_rs;
   logic [4:0]          w_rt;
   logic [4:0]          w_rd;
   logic [4:0]          w_dec_rd;
   logic [9:0]          w_dec_bits;
   logic                w_dec_illegal;
   logic [24:0]         w_dec_ctrl;
   logic [JADDR_W-1:0]  w_dec_jaddr;

   logic                w_slot_open;
   logic                w_hazard;
   logic                w_xfer;
   logic                w_out_hs;
   logic                w_squash;

   assign w_opcode = bus.instr[31:26];
   assign w_funct  = bus.instr[5:0];
   assign w_rs     = bus.instr[25:21];
   assign w_rt     = bus.instr[20:16];
   assign w_rd     = bus.instr[15:11];

   // Combinational decode of the presented instruction
   always_comb begin
      w_dec_bits    = '0;
      w_dec_rd      = '0;
      w_dec_illegal = 1'b0;
      case (w_opcode)
         OP_LW:   begin w_dec_bits = C_LW;   w_dec_rd = w_rt; end
         OP_SW:   begin w_dec_bits = C_SW;   w_dec_rd = w_rs; end
         OP_BNE:  begin w_dec_bits = C_BNE;  w_dec_rd = '0;   end
         OP_ADDI: begin w_dec_bits = C_ADDI; w_dec_rd = w_rt; end
         OP_ORI:  begin w_dec_bits = C_ORI;  w_dec_rd = w_rt; end
         OP_J:    begin w_dec_bits = C_J;    w_dec_rd = '0;   end
         default: begin
            case (w_funct)
               FN_ADD:  begin w_dec_bits = C_ADD; w_dec_rd = w_rd; end
               FN_SUB:  begin w_dec_bits = C_SUB; w_dec_rd = w_rd; end
               FN_MUL:  begin w_dec_bits = C_MUL; w_dec_rd = w_rd; end
               FN_AND:  begin w_dec_bits = C_AND; w_dec_rd = w_rd; end
               FN_OR:   begin w_dec_bits = C_OR;  w_dec_rd = w_rd; end
               default: w_dec_illegal = 1'b1;
            endcase
         end
      endcase
   end

   // An undecodable word becomes a full NOP: no register fields leak through.
   assign w_dec_ctrl  = w_dec_illegal ? 25'd0 : {w_rs, w_rt, w_dec_rd, w_dec_bits};
   assign w_dec_jaddr = (w_opcode == OP_J) ? JADDR_W'(bus.instr[25:0]) : '0;

   // Handshake qualifiers. The squash slot must be able to accept its victim,
   // so input is open in both RUN and SQUASH; only MUL_WAIT closes it.
   assign w_out_hs    = r_out_valid && bus.out_ready;
   assign w_slot_open = (!r_out_valid || bus.out_ready) && (r_state != ST_MUL_WAIT);
   // A word is dropped if a jump is in SQUASH already, or is leaving the
   // output register in the very cycle the next word is accepted.
   assign w_squash    = (r_state == ST_SQUASH) || (w_out_hs && r_ctrl[B_JMP]);
   assign w_xfer      = bus.in_valid && w_slot_open && !w_hazard;

`ifdef CTRL_LOAD_USE_INTERLOCK_EN
   logic [4:0] r_last_lw_rt;
   logic       r_last_lw_vld;
   logic       w_is_lw;
   logic       w_uses_rt;
   logic [4:0] w_dec_rs;
   logic [4:0] w_dec_rt;

   // Decoded fields are zero for illegal words, so those never match.
   assign w_dec_rs  = w_dec_ctrl[24:20];
   assign w_dec_rt  = w_dec_ctrl[19:15];
   assign w_is_lw   = (w_opcode == OP_LW);
   // rt is a source for R-type, sw and bne; a destination for lw/addi/ori.
   assign w_uses_rt = !((w_opcode == OP_LW) || (w_opcode == OP_ADDI) ||
                        (w_opcode == OP_ORI) || (w_opcode == OP_J));

   // The squashed word is never executed, so it is exempt from the check.
   assign w_hazard  = bus.in_valid && (r_state == ST_RUN) && !w_squash &&
                      r_last_lw_vld && (r_last_lw_rt != 5'd0) &&
                      ((w_dec_rs == r_last_lw_rt) ||
                       (w_uses_rt && (w_dec_rt == r_last_lw_rt)));

   // Track the destination of the last issued lw for one issue slot; the
   // slot is spent either by the next issue or by one real stall cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_last_lw_rt  <= '0;
         r_last_lw_vld <= 1'b0;
      end else if (w_xfer) begin
         r_last_lw_rt  <= w_dec_rt;
         r_last_lw_vld <= w_is_lw && !w_squash;
      end else if (w_hazard && w_slot_open) begin
         r_last_lw_vld <= 1'b0;
      end
   end
`else
   assign w_hazard = 1'b0;
`endif

   // One-entry output register; holds steady under backpressure
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_out_valid <= 1'b0;
         r_ctrl      <= '0;
         r_jaddr     <= '0;
         r_illegal   <= 1'b0;
      end else if (w_xfer) begin
         if (w_squash) begin
            r_out_valid <= 1'b0;
         end else begin
            r_out_valid <= 1'b1;
            r_ctrl      <= w_dec_ctrl;
            r_jaddr     <= w_dec_jaddr;
            r_illegal   <= w_dec_illegal;
         end
      end else if (w_out_hs) begin
         r_out_valid <= 1'b0;
      end
   end

   // Sequencer state, multiplier countdown and deferred-squash flag
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_RUN;
         r_cnt     <= '0;
         r_sq_pend <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_cnt     <= w_cnt_next;
         r_sq_pend <= w_sq_pend_next;
      end
   end

   // Next-state logic. A mul leaving starts MUL_WAIT; a j leaving arms SQUASH
   // unless its victim is accepted in the same cycle. A word that was already
   // in the output register when MUL_WAIT began may still leave during it: a
   // second mul restarts the countdown, a j defers SQUASH until the wait ends.
   always_comb begin
      w_state_next   = r_state;
      w_cnt_next     = r_cnt;
      w_sq_pend_next = r_sq_pend;
      case (r_state)
         ST_RUN: begin
            if (w_out_hs && r_ctrl[B_MUL]) begin
               w_state_next = ST_MUL_WAIT;
               w_cnt_next   = CNT_LOAD;
            end else if (w_out_hs && r_ctrl[B_JMP] && !w_xfer) begin
               w_state_next = ST_SQUASH;
            end
         end
         ST_MUL_WAIT: begin
            if (w_out_hs && r_ctrl[B_JMP]) begin
               w_sq_pend_next = 1'b1;
            end
            if (w_out_hs && r_ctrl[B_MUL]) begin
               w_cnt_next = CNT_LOAD;
            end else if (r_cnt == '0) begin
               w_state_next   = (r_sq_pend || (w_out_hs && r_ctrl[B_JMP])) ?
                                ST_SQUASH : ST_RUN;
               w_sq_pend_next = 1'b0;
            end else begin
               w_cnt_next = r_cnt - CNT_W'(1);
            end
         end
         ST_SQUASH: begin
            if (w_xfer) begin
               w_state_next = ST_RUN;
            end
         end
         default: begin
            w_state_next = ST_RUN;
         end
      endcase
   end

   assign bus.in_ready  = w_slot_open && !w_hazard;
   assign bus.out_valid = r_out_valid;
   assign bus.ctrl      = r_ctrl;
   assign bus.jmp_addr  = r_jaddr;
   assign bus.jmp_flag  = r_ctrl[B_JMP];
   assign bus.illegal   = r_illegal;

endmodule
